// File: rtl/bcd_scan_counter_pkg.sv
// Shared types and constants for the scanned BCD counter.
//   bcd_t     : one BCD decade (0..9)
//   BCD_MAX   : largest legal decade value
//   BCD_ZERO  : decade reset value
package bcd_scan_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_scan_counter_bcd_digit.sv
// One decade of the BCD counter.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   en_up      : increment this decade (carry in from the lower decade)
//   en_dn      : decrement this decade (borrow in from the lower decade)
//   clr        : synchronous clear to zero
//   q          : current decade value
//   carry_out  : this decade wraps 9->0 on this increment
//   borrow_out : this decade wraps 0->9 on this decrement
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_up,
  input  logic en_dn,
  input  logic clr,
  output bcd_t q,
  output logic carry_out,
  output logic borrow_out
);

  // The top guarantees en_up and en_dn are never both high.
  assign carry_out  = (q == BCD_MAX)  & en_up;
  assign borrow_out = (q == BCD_ZERO) & en_dn;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= BCD_ZERO;
    end else if (clr) begin
      q <= BCD_ZERO;
    end else if (en_up) begin
      q <= (q == BCD_MAX) ? BCD_ZERO : q + 4'd1;
    end else if (en_dn) begin
      q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed scan output
// feeding a 7-segment decoder.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   inc, dec   : count-up / count-down requests (ignored when both high)
//   clr        : synchronous clear of the count (has priority)
//   x,y,z,w    : scanned digit BCD nibble, x = weight 8, w = weight 1
//   digit_en   : one-hot digit select, all-zero on a blanked slot
//   value      : parallel BCD count, digit i at [4i+3:4i]
//   ovf, unf   : one-cycle pulses on wrap all-9s->0 and 0->all-9s
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    dec,
  input  logic                    clr,
  output logic                    x,
  output logic                    y,
  output logic                    z,
  output logic                    w,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    ovf,
  output logic                    unf
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic                  count_up;
  logic                  count_dn;
  logic [NUM_DIGITS:0]   carry;
  logic [NUM_DIGITS:0]   borrow;
  logic [PRE_W-1:0]      prescale;
  logic [IDX_W-1:0]      scan_idx;
  logic [IDX_W-1:0]      next_idx;
  logic [NUM_DIGITS-1:0] live;
  logic                  acc;
  logic [NUM_DIGITS-1:0] en_next;
  bcd_t                  nib_next;

  // clr wins outright; inc and dec together cancel.
  assign count_up  = ~clr & inc & ~dec;
  assign count_dn  = ~clr & dec & ~inc;
  assign carry[0]  = count_up;
  assign borrow[0] = count_dn;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_up      (carry[i]),
      .en_dn      (borrow[i]),
      .clr        (clr),
      .q          (value[4*i +: 4]),
      .carry_out  (carry[i+1]),
      .borrow_out (borrow[i+1])
    );
  end

  // A carry/borrow out of the top decade is exactly the full-range wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= carry[NUM_DIGITS];
      unf <= borrow[NUM_DIGITS];
    end
  end

  // The index of the slot being loaded into the output registers this edge.
  always_comb begin
    next_idx = scan_idx;
    if (prescale == PRE_LAST) begin
      next_idx = (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  // live[i] is set when digit i or any higher digit is nonzero; digit 0
  // always shows so that a zero count still displays one "0".
  always_comb begin
    live = '0;
    acc  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc     = acc | (value[4*i +: 4] != BCD_ZERO);
      live[i] = acc;
    end
    live[0] = 1'b1;
  end

  always_comb begin
    en_next  = '0;
    nib_next = BCD_ZERO;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((next_idx == IDX_W'(i)) && live[i]) begin
        en_next[i] = 1'b1;
        nib_next   = value[4*i +: 4];
      end
    end
  end

  // Select and nibble are registered on the same edge so they never skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale     <= '0;
      scan_idx     <= '0;
      digit_en     <= NUM_DIGITS'(1);
      {x, y, z, w} <= BCD_ZERO;
    end else begin
      prescale     <= (prescale == PRE_LAST) ? '0 : prescale + PRE_W'(1);
      scan_idx     <= next_idx;
      digit_en     <= en_next;
      {x, y, z, w} <= nib_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (4 digits, 4 clocks per slot).
// The reference model keeps the count as a plain integer 0..9999 and the
// scan position as the number of clock edges since the last reset edge.
module tb_bcd_scan_counter;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inc = 1'b0;
  logic          dec = 1'b0;
  logic          clr = 1'b0;
  logic          x, y, z, w;
  logic [ND-1:0] digit_en;
  logic [4*ND-1:0] value;
  logic          ovf, unf;

  logic [25:0]   observed;

  int n_compared = 0;
  int n_mismatched = 0;

  int   m_value = 0;
  int   m_disp = 0;
  int   m_cycle = 0;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  bcd_scan_counter #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inc),
    .dec      (dec),
    .clr      (clr),
    .x        (x),
    .y        (y),
    .z        (z),
    .w        (w),
    .digit_en (digit_en),
    .value    (value),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  assign observed = {value, digit_en, x, y, z, w, ovf, unf};

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic int cur_slot();
    return (m_cycle / SD) % ND;
  endfunction

  // Expected {value, digit_en, xyzw, ovf, unf} derived from decimal arithmetic.
  function automatic logic [25:0] exp_bundle();
    logic [15:0] bv;
    logic [3:0]  en;
    logic [3:0]  nib;
    int          s;
    bv = '0;
    for (int i = 0; i < ND; i++) bv[4*i +: 4] = 4'((m_value / pow10(i)) % 10);
    s   = cur_slot();
    en  = '0;
    nib = '0;
    if (s == 0 || m_disp >= pow10(s)) begin
      en[s] = 1'b1;
      nib   = 4'((m_disp / pow10(s)) % 10);
    end
    return {bv, en, nib, m_ovf, m_unf};
  endfunction

  // Drives one cycle of inputs and advances the model across the edge.
  task automatic tick(input logic i_inc, input logic i_dec, input logic i_clr);
    inc = i_inc;
    dec = i_dec;
    clr = i_clr;
    @(posedge clk);
    if (!rst_n) begin
      m_value = 0;
      m_disp  = 0;
      m_cycle = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      m_disp  = m_value;
      m_cycle = m_cycle + 1;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      if (i_clr) begin
        m_value = 0;
      end else if (i_inc && !i_dec) begin
        if (m_value == pow10(ND) - 1) begin
          m_value = 0;
          m_ovf   = 1'b1;
        end else begin
          m_value = m_value + 1;
        end
      end else if (i_dec && !i_inc) begin
        if (m_value == 0) begin
          m_value = pow10(ND) - 1;
          m_unf   = 1'b1;
        end else begin
          m_value = m_value - 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) tick(0, 0, 0);
    n_compared++;
    if (observed !== 26'({16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b0})) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state got %h want %h", observed,
               26'({16'h0000, 4'b0001, 4'b0000, 1'b0, 1'b0}));
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick(0, 0, 0);
      n_compared++;
      if (observed !== exp_bundle()) begin
        n_mismatched++;
        $display("[TB] FAIL reset_scan cyc %0d got %h want %h", k, observed, exp_bundle());
      end
    end
  endtask

  task automatic test_carry();
    tick(0, 0, 1);
    for (int k = 0; k < 999; k++) tick(1, 0, 0);
    n_compared++;
    if (value !== 16'h0999) begin
      n_mismatched++;
      $display("[TB] FAIL preload_999 got %h want %h", value, 16'h0999);
    end
    tick(1, 0, 0);
    n_compared++;
    if (value !== 16'h1000) begin
      n_mismatched++;
      $display("[TB] FAIL carry_1000 got %h want %h", value, 16'h1000);
    end
    tick(0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      tick(0, 0, 0);
      n_compared++;
      if (observed !== exp_bundle() || digit_en === 4'b0000) begin
        n_mismatched++;
        $display("[TB] FAIL carry_scan cyc %0d got %h want %h", k, observed, exp_bundle());
      end
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 1);
    tick(0, 1, 0);
    n_compared++;
    if (value !== 16'h9999 || unf !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL wrap_to_max got %h/%b want 9999/1", value, unf);
    end
    tick(1, 0, 0);
    n_compared++;
    if (value !== 16'h0000 || ovf !== 1'b1 || unf !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ovf_pulse got %h ovf %b unf %b want 0000 1 0", value, ovf, unf);
    end
    tick(0, 0, 0);
    n_compared++;
    if (ovf !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ovf_one_cycle got %b want 0", ovf);
    end
    tick(0, 1, 0);
    n_compared++;
    if (value !== 16'h9999 || unf !== 1'b1 || ovf !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL unf_pulse got %h unf %b ovf %b want 9999 1 0", value, unf, ovf);
    end
    tick(0, 0, 0);
    n_compared++;
    if (unf !== 1'b0 || observed !== exp_bundle()) begin
      n_mismatched++;
      $display("[TB] FAIL unf_one_cycle got %h want %h", observed, exp_bundle());
    end
  endtask

  task automatic test_priority();
    int slot_before;
    tick(0, 0, 1);
    for (int k = 0; k < 42; k++) tick(1, 0, 0);
    tick(1, 1, 0);
    n_compared++;
    if (value !== 16'h0042 || ovf !== 1'b0 || unf !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL inc_dec_hold got %h want %h", value, 16'h0042);
    end
    slot_before = cur_slot();
    tick(1, 0, 1);
    n_compared++;
    if (value !== 16'h0000 || ovf !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL clr_priority got %h ovf %b want 0000 0", value, ovf);
    end
    n_compared++;
    if (observed !== exp_bundle() || cur_slot() != (slot_before + (m_cycle % SD == 0 ? 1 : 0)) % ND) begin
      n_mismatched++;
      $display("[TB] FAIL clr_keeps_scan got %h want %h", observed, exp_bundle());
    end
    for (int k = 0; k < 8; k++) begin
      tick(0, 0, 0);
      n_compared++;
      if (observed !== exp_bundle()) begin
        n_mismatched++;
        $display("[TB] FAIL post_clr_scan cyc %0d got %h want %h", k, observed, exp_bundle());
      end
    end
  endtask

  task automatic test_scan_coherence();
    logic [3:0] want_en [4];
    logic [3:0] want_nib [4];
    want_en  = '{4'b0001, 4'b0010, 4'b0100, 4'b0000};
    want_nib = '{4'd5, 4'd0, 4'd3, 4'd0};
    tick(0, 0, 1);
    for (int k = 0; k < 305; k++) tick(1, 0, 0);
    tick(0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 0);
      n_compared++;
      if (digit_en !== want_en[cur_slot()] || {x, y, z, w} !== want_nib[cur_slot()]) begin
        n_mismatched++;
        $display("[TB] FAIL scan_0305 slot %0d got en %b xyzw %b want en %b xyzw %b",
                 cur_slot(), digit_en, {x, y, z, w}, want_en[cur_slot()], want_nib[cur_slot()]);
      end
    end
  endtask

  task automatic test_random();
    logic r_inc, r_dec, r_clr;
    for (int k = 0; k < 600; k++) begin
      r_inc = 1'($urandom_range(0, 1));
      r_dec = 1'($urandom_range(0, 1));
      r_clr = ($urandom_range(0, 40) == 0);
      tick(r_inc, r_dec, r_clr);
      n_compared++;
      if (observed !== exp_bundle()) begin
        n_mismatched++;
        $display("[TB] FAIL random cyc %0d got %h want %h", k, observed, exp_bundle());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want_seq [5];
    want_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tick(0, 0, 1);
    for (int k = 0; k < 1234; k++) tick(1, 0, 0);
    for (int k = 0; k < 2 * SD * ND && cur_slot() != 2; k++) tick(0, 0, 0);
    n_compared++;
    if (value !== 16'h1234 || cur_slot() != 2) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid_setup got %h slot %0d want 1234 slot 2", value, cur_slot());
    end
    rst_n = 1'b0;
    tick(0, 0, 0);
    rst_n = 1'b1;
    n_compared++;
    if (value !== 16'h0000 || digit_en !== want_seq[0] || ovf !== 1'b0 || unf !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid got %h en %b want 0000 en 0001", value, digit_en);
    end
    for (int k = 1; k < 5; k++) begin
      tick(0, 0, 0);
      n_compared++;
      if (digit_en !== want_seq[k] || observed !== exp_bundle()) begin
        n_mismatched++;
        $display("[TB] FAIL reset_mid_slot cyc %0d got en %b want en %b", k, digit_en, want_seq[k]);
      end
    end
  endtask

  initial begin
    $display("[TB] bcd_scan_counter bench start");
    test_reset();
    test_carry();
    test_wrap();
    test_priority();
    test_scan_coherence();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
